// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, operand/accumulator types and the
// saturating-add helper for the systolic_array block.
// Optional feature macro: SYSTOLIC_SAT_EN (sat_add is only referenced when
// it is defined).
package systolic_pkg;
  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  typedef logic signed [DEF_BITS_AB-1:0] ab_t;
  typedef logic signed [DEF_BITS_C-1:0]  c_t;

  // Signed add clamped to the w-bit two's complement range. Operands are
  // carried in 32 bits so one helper serves any accumulator width <= 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [33:0] s, hi, lo;
    s  = 34'(a) + 34'(b);
    hi = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo = -(34'sd1 <<< (w - 1));
    if (s > hi)      return 32'(hi);
    else if (s < lo) return 32'(lo);
    return 32'(s);
  endfunction
endpackage

// File: rtl/systolic_if.sv
// systolic_if: operand, C write/read and status bundle of systolic_array.
//   en    : advance pipelines / accumulate
//   WrEn  : write Cin into C row Crow
//   Crow  : C row select for write and read
//   Ain   : A into column 0 (Ain[r] feeds row r)
//   Bin   : B into row 0 (Bin[c] feeds column c)
//   Cin   : C row write data
//   Cout  : C row read data (combinational)
//   done  : step counter reached 3*DIM-2
// master = driver of the array, slave = the array itself.
interface systolic_if
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
);
  localparam int CW = $clog2(DIM);

  logic                          en;
  logic                          WrEn;
  logic [CW-1:0]                 Crow;
  logic [DIM-1:0][BITS_AB-1:0]   Ain;
  logic [DIM-1:0][BITS_AB-1:0]   Bin;
  logic [DIM-1:0][BITS_C-1:0]    Cin;
  logic [DIM-1:0][BITS_C-1:0]    Cout;
  logic                          done;

  modport master (output en, WrEn, Crow, Ain, Bin, Cin, input Cout, done);
  modport slave  (input en, WrEn, Crow, Ain, Bin, Cin, output Cout, done);
endinterface

// File: rtl/systolic_cell.sv
// systolic_cell: one multiply-accumulate node of the grid.
//   clk, rst : clock, synchronous active-high reset
//   i_en     : register A/B and accumulate
//   i_wr     : load i_cin into C (wins over accumulate)
//   i_a/i_b  : operands arriving from the left / from above
//   i_cin    : C write data
//   o_a/o_b  : registered operands passed right / down
//   o_c      : accumulator
// With SYSTOLIC_SAT_EN defined the product and the sum are clamped to the
// BITS_C range instead of wrapping.
module systolic_cell
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_wr,
  input  logic [BITS_AB-1:0] i_a,
  input  logic [BITS_AB-1:0] i_b,
  input  logic [BITS_C-1:0]  i_cin,
  output logic [BITS_AB-1:0] o_a,
  output logic [BITS_AB-1:0] o_b,
  output logic [BITS_C-1:0]  o_c
);
  logic signed [2*BITS_AB-1:0] w_prod;
  logic [BITS_C-1:0]           w_sum;
  logic [BITS_AB-1:0]          r_a, r_b;
  logic [BITS_C-1:0]           r_c;

  // Product uses the incoming operands, not the registered ones, so the
  // cell multiplies what it is latching on the same edge.
  assign w_prod = $signed(i_a) * $signed(i_b);

`ifdef SYSTOLIC_SAT_EN
  logic signed [31:0] w_pclamp, w_acc;
  assign w_pclamp = sat_add(32'sd0, 32'(w_prod), BITS_C);
  assign w_acc    = sat_add(32'($signed(r_c)), w_pclamp, BITS_C);
  assign w_sum    = BITS_C'(w_acc);
`else
  logic [BITS_C-1:0] w_prod_c;
  // Sign-extends or truncates depending on BITS_C vs 2*BITS_AB.
  assign w_prod_c = BITS_C'(w_prod);
  assign w_sum    = r_c + w_prod_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else begin
      if (i_en) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      if (i_wr)      r_c <= i_cin;
      else if (i_en) r_c <= w_sum;
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c;
endmodule

// File: rtl/systolic_array.sv
// systolic_array: DIM x DIM signed MAC grid. A flows left-to-right, B flows
// top-to-bottom, each cell accumulates into its own C register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : systolic_if.slave (operands, C row write/read, done)
// Optional feature macro: SYSTOLIC_SAT_EN (saturating accumulate, handled in
// systolic_cell; counter and done are unaffected).
module systolic_array
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int BITS_C  = DEF_BITS_C,
  parameter int DIM     = DEF_DIM
) (
  input  logic       clk,
  input  logic       rst,
  systolic_if.slave  bus
);
  localparam int CW    = $clog2(DIM);
  localparam int CNTW  = $clog2(3 * DIM);
  localparam int STEPS = 3 * DIM - 2;

  // w_a[r][c] is the A input of cell (r,c); column DIM is the spill-out.
  // w_b[r][c] is the B input of cell (r,c); row DIM is the spill-out.
  logic [DIM-1:0][DIM:0][BITS_AB-1:0]   w_a;
  logic [DIM:0][DIM-1:0][BITS_AB-1:0]   w_b;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  w_c;
  logic [DIM-1:0]                       w_row_wr;
  logic                                 w_unused;

  for (genvar c = 0; c < DIM; c++) begin : g_bin
    assign w_b[0][c] = bus.Bin[c];
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign w_a[r][0]   = bus.Ain[r];
    // Out-of-range Crow (non power-of-2 DIM) matches no row: write dropped.
    assign w_row_wr[r] = bus.WrEn && (bus.Crow == CW'(r));
    for (genvar c = 0; c < DIM; c++) begin : g_col
      systolic_cell #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .i_en  (bus.en),
        .i_wr  (w_row_wr[r]),
        .i_a   (w_a[r][c]),
        .i_b   (w_b[r][c]),
        .i_cin (bus.Cin[c]),
        .o_a   (w_a[r][c+1]),
        .o_b   (w_b[r+1][c]),
        .o_c   (w_c[r][c])
      );
    end
  end

  // Operands leaving the right and bottom edges go nowhere.
  always_comb begin
    w_unused = ^w_b[DIM];
    for (int r = 0; r < DIM; r++) w_unused = w_unused ^ (^w_a[r][DIM]);
  end

  // Row read mux; an unmatched Crow reads 0.
  always_comb begin
    bus.Cout = '0;
    for (int r = 0; r < DIM; r++)
      if (bus.Crow == CW'(r)) bus.Cout = w_c[r];
  end

  // Step counter: WrEn restarts it, en advances it up to STEPS and holds.
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_done;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.WrEn)                                w_cnt_nxt = '0;
    else if (bus.en && (r_cnt != CNTW'(STEPS)))  w_cnt_nxt = r_cnt + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= (w_cnt_nxt == CNTW'(STEPS));
    end
  end

  assign bus.done = r_done;
endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed bench for systolic_array (DIM=8, 8/16 bits).
// A reference model tracks operand history per en step and derives every
// cell's C from the matrix-flow rule; a negedge process compares Cout/done
// against it each cycle, and literal checks pin the model.
module tb_systolic_array;
  import systolic_pkg::*;
  localparam int D  = 8;
  localparam int NS = 3 * D - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_if #(.BITS_AB(8), .BITS_C(16), .DIM(D)) bus ();
  systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // ---------------- reference model ----------------
  logic [D-1:0][7:0] qa[$];
  logic [D-1:0][7:0] qb[$];
  int mc[D][D];
  int mcnt;

  function automatic int acc(input int c, input int p);
    logic [15:0] t;
`ifdef SYSTOLIC_SAT_EN
    int pc, s;
    pc = (p > 32767) ? 32767 : (p < -32768) ? -32768 : p;
    s  = c + pc;
    return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
`else
    t = 16'(c + p);
    return int'($signed(t));
`endif
  endfunction

  always @(posedge clk) begin
    int nc[D][D];
    int k, a, b;
    logic [D-1:0][7:0] va, vb;
    if (rst) begin
      qa.delete();
      qb.delete();
      for (int r = 0; r < D; r++) for (int c = 0; c < D; c++) mc[r][c] = 0;
      mcnt = 0;
    end else begin
      nc = mc;
      if (bus.en) begin
        qa.push_back(bus.Ain);
        qb.push_back(bus.Bin);
        k = qa.size() - 1;
        // Cell (r,c) sees the A that entered c steps ago and the B that
        // entered r steps ago.
        for (int r = 0; r < D; r++)
          for (int c = 0; c < D; c++) begin
            a = 0; b = 0;
            if (k - c >= 0) begin va = qa[k-c]; a = int'($signed(va[r])); end
            if (k - r >= 0) begin vb = qb[k-r]; b = int'($signed(vb[c])); end
            nc[r][c] = acc(mc[r][c], a * b);
          end
      end
      if (bus.WrEn)
        for (int c = 0; c < D; c++) nc[bus.Crow][c] = int'($signed(bus.Cin[c]));
      mc = nc;
      if (bus.WrEn) mcnt = 0;
      else if (bus.en && mcnt < NS) mcnt = mcnt + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [D-1:0][15:0] er;
    if (chk_on) begin
      for (int c = 0; c < D; c++) er[c] = 16'(mc[bus.Crow][c]);
      checks++;
      if (bus.Cout !== er) begin
        failures++;
        $display("FAIL model_cout row=%0d got=%h expected=%h", bus.Crow, bus.Cout, er);
      end
      checks++;
      if (bus.done !== (mcnt == NS)) begin
        failures++;
        $display("FAIL model_done got=%b expected=%b", bus.done, (mcnt == NS));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int mA[D][D];
  int mB[D][D];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input int r, input int e[D]);
    bus.Crow = 3'(r);
    #1;
    for (int c = 0; c < D; c++) chk(nm, int'($signed(bus.Cout[c])), e[c]);
  endtask

  // Skewed feed: row r of A delayed by r steps, column c of B by c steps.
  task automatic drive_step(input int t);
    for (int i = 0; i < D; i++) begin
      bus.Ain[i] = (t - i >= 0 && t - i < D) ? 8'(mA[i][t-i]) : 8'h00;
      bus.Bin[i] = (t - i >= 0 && t - i < D) ? 8'(mB[t-i][i]) : 8'h00;
    end
  endtask

  task automatic en_step(input int t);
    drive_step(t);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic clear_rows();
    bus.en   = 1'b0;
    bus.Cin  = '0;
    bus.WrEn = 1'b1;
    for (int r = 0; r < D; r++) begin bus.Crow = 3'(r); tick(); end
    bus.WrEn = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic set_identity();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        mA[i][j] = (i == j) ? 1 : 0;
        mB[i][j] = i * 8 + j;
      end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e[D];
    bus.en = 1'b0; bus.WrEn = 1'b0; bus.Crow = '0;
    bus.Ain = '0; bus.Bin = '0; bus.Cin = '0;

    // Reset held two cycles with activity on the inputs.
    rst = 1'b1; bus.en = 1'b1;
    bus.Ain = {D{8'h11}}; bus.Bin = {D{8'h22}};
    tick(); chk_on = 1'b1; tick();
    for (int c = 0; c < D; c++) e[c] = 0;
    for (int r = 0; r < D; r++) chk_row("reset_cout", r, e);
    chk("reset_done", int'(bus.done), 0);
    bus.en = 1'b0; bus.Ain = '0; bus.Bin = '0;
    tick(); rst = 1'b0;

    // Identity multiply: C = I * B = B.
    set_identity();
    for (int t = 0; t < NS; t++) begin
      en_step(t);
      if (t == NS - 2) chk("ident_done_early", int'(bus.done), 0);
    end
    chk("ident_done", int'(bus.done), 1);
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) e[c] = r * 8 + c;
      chk_row("ident_row", r, e);
    end

    // Preload row 3 with 100, then accumulate I * (all 2).
    clear_rows();
    bus.WrEn = 1'b1; bus.Crow = 3'd3;
    for (int c = 0; c < D; c++) bus.Cin[c] = 16'd100;
    tick();
    bus.WrEn = 1'b0;
    chk("preload_done_drop", int'(bus.done), 0);
    for (int i = 0; i < D; i++) for (int j = 0; j < D; j++) mB[i][j] = 2;
    for (int t = 0; t < NS; t++) en_step(t);
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) e[c] = (r == 3) ? 102 : 2;
      chk_row("preload_row", r, e);
    end

    // WrEn row 0 together with en at stream step 5.
    clear_rows();
    for (int t = 0; t < 5; t++) en_step(t);
    drive_step(5);
    bus.WrEn = 1'b1; bus.Crow = 3'd0; bus.en = 1'b1;
    for (int c = 0; c < D; c++) bus.Cin[c] = 16'd5;
    tick();
    bus.WrEn = 1'b0; bus.en = 1'b0;
    for (int c = 0; c < D; c++) e[c] = 5;
    chk_row("wr_en_row0_now", 0, e);
    for (int t = 6; t < 6 + NS; t++) begin
      en_step(t);
      if (t == 4 + NS) chk("wr_en_done_early", int'(bus.done), 0);
    end
    chk("wr_en_done", int'(bus.done), 1);
    for (int c = 0; c < D; c++) e[c] = (c >= 6) ? 7 : 5;
    chk_row("wr_en_row0_final", 0, e);
    for (int c = 0; c < D; c++) e[c] = 2;
    chk_row("wr_en_row1_final", 1, e);
    chk_row("wr_en_row7_final", 7, e);

    // Overflow at cell (0,0): three accumulates of 127*127.
    do_reset();
    bus.Ain = '0; bus.Bin = '0;
    bus.Ain[0] = 8'sd127; bus.Bin[0] = 8'sd127;
    bus.en = 1'b1;
    tick(); tick(); tick();
    bus.en = 1'b0; bus.Ain = '0; bus.Bin = '0;
    bus.Crow = 3'd0;
    #1;
`ifdef SYSTOLIC_SAT_EN
    chk("overflow_c00", int'($signed(bus.Cout[0])), 32767);
`else
    chk("overflow_c00", int'($signed(bus.Cout[0])), -17149);
`endif
    chk("overflow_c01", int'($signed(bus.Cout[1])), 0);

    // Identity again with en bubbles carrying junk operands.
    do_reset();
    set_identity();
    for (int t = 0; t < NS; t++) begin
      en_step(t);
      if (t == 3 || t == 9 || t == 15) begin
        bus.Ain = {D{8'h7f}}; bus.Bin = {D{8'h81}};
        tick();
      end
      if (t == NS - 2) chk("gap_done_early", int'(bus.done), 0);
    end
    chk("gap_done", int'(bus.done), 1);
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) e[c] = r * 8 + c;
      chk_row("gap_row", r, e);
    end

    tick();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
